seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/seg_scan_prescaler.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the seven-segment scan controller.
//   SEG_BLANK   - all segments off (active-low)
//   AN_OFF      - all anodes off (active-low)
//   ERR_PATTERN - "Er", {left digit, right digit}, active-low gfedcba
//   digit_e     - which of the two scanned digits is currently lit
package seg_scan_pkg;

  localparam logic [6:0]  SEG_BLANK   = 7'h7F;
  localparam logic [3:0]  AN_OFF      = 4'hF;
  localparam logic [13:0] ERR_PATTERN = 14'b0000110_0101111;

  typedef enum logic {
    D0 = 1'b0,  // right digit, seg_in[6:0]
    D1 = 1'b1   // left digit, seg_in[13:7]
  } digit_e;

  // Active-low anode enable for a scanned digit; an[3:2] stay off.
  function automatic logic [3:0] an_for(input digit_e d);
    return (d == D0) ? 4'b1110 : 4'b1101;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler: free-running digit dwell counter 0..DIGIT_TICKS-1.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tick_o    - current tick count
//   wrap_o    - high in the last tick of a digit period (counter wraps next edge)
module seg_scan_prescaler #(
  parameter int DIGIT_TICKS = 50_000,
  parameter int TW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic [TW-1:0] tick_o,
  output logic          wrap_o
);

  localparam logic [TW-1:0] LAST = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    wrap_o = (tick_q == LAST);
    tick_d = wrap_o ? '0 : tick_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit time-multiplexed scan controller for a common-anode
// seven-segment display, with a pending/shadow double buffer so a new pattern
// only takes effect at a frame boundary.
// Optional feature macro: SEG_SCAN_BLINK_EN (blink the "Er" pattern).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   seg_in     - {left digit, right digit}, active-low gfedcba
//   seg_valid  - seg_in valid
//   seg_ready  - pending buffer empty
//   seg_out    - active-low segments of the lit digit
//   an_out     - active-low anodes (an_out[3:2] always off)
//   frame_tick - one-cycle pulse in the first cycle of each frame
// Handshake: a pattern transfers on a rising edge where seg_valid && seg_ready;
// a source that sees seg_ready low must hold seg_in and seg_valid unchanged.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_TICKS  = 50_000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] seg_in,
  input  logic        seg_valid,
  output logic        seg_ready,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        frame_tick
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;

  logic [TW-1:0] tick;
  logic          digit_wrap;

  seg_scan_prescaler #(.DIGIT_TICKS(DIGIT_TICKS), .TW(TW)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick),
    .wrap_o (digit_wrap)
  );

  digit_e      idx_q, idx_d;
  logic [13:0] pending_q, pending_d;
  logic        pending_full_q, pending_full_d;
  logic [13:0] shadow_q, shadow_d;
  logic [6:0]  seg_out_q, seg_out_d;
  logic [3:0]  an_out_q, an_out_d;
  logic        seg_ready_q, seg_ready_d;
  logic        frame_tick_q, frame_tick_d;
  logic        boundary;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
`endif

  always_comb begin
    boundary       = digit_wrap && (idx_q == D1);
    idx_d          = idx_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    shadow_d       = shadow_q;

    if (digit_wrap) idx_d = (idx_q == D0) ? D1 : D0;

    if (boundary && pending_full_q) begin
      shadow_d       = pending_q;
      pending_full_d = 1'b0;
    end

    // seg_ready_q is always !pending_full_q out of reset, so an accept can
    // never collide with an unread pending pattern.
    if (seg_valid && seg_ready_q) begin
      pending_d      = seg_in;
      pending_full_d = 1'b1;
    end

    // Display outputs are the registered image of the current scan state, so
    // anode and segments change together and each frame starts cleanly.
    an_out_d     = an_for(idx_q);
    seg_out_d    = (idx_q == D0) ? shadow_q[6:0] : shadow_q[13:7];
    frame_tick_d = (idx_q == D0) && (tick == '0);
    // Built from the next pending state so the flag is current on every edge.
    seg_ready_d  = !pending_full_d;

`ifdef SEG_SCAN_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    if (boundary) begin
      if (pending_full_q)             blink_cnt_d = '0;
      else if (blink_cnt_q == BLINK_LAST) blink_cnt_d = '0;
      else                            blink_cnt_d = blink_cnt_q + BW'(1);
    end
    if ((shadow_q == ERR_PATTERN) && (blink_cnt_q >= BLINK_HALF)) an_out_d = AN_OFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= D0;
      pending_q      <= {SEG_BLANK, SEG_BLANK};
      pending_full_q <= 1'b0;
      shadow_q       <= {SEG_BLANK, SEG_BLANK};
      seg_out_q      <= SEG_BLANK;
      an_out_q       <= AN_OFF;
      seg_ready_q    <= 1'b0;
      frame_tick_q   <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      blink_cnt_q    <= '0;
`endif
    end else begin
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      shadow_q       <= shadow_d;
      seg_out_q      <= seg_out_d;
      an_out_q       <= an_out_d;
      seg_ready_q    <= seg_ready_d;
      frame_tick_q   <= frame_tick_d;
`ifdef SEG_SCAN_BLINK_EN
      blink_cnt_q    <= blink_cnt_d;
`endif
    end
  end

  assign seg_out    = seg_out_q;
  assign an_out     = an_out_q;
  assign seg_ready  = seg_ready_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (DIGIT_TICKS=4,
// BLINK_FRAMES=2). A frame-level reference model predicts the outputs of every
// cycle; predictions go into exp_q and a negedge monitor compares them.
module tb_seg_scan_ctrl;

  localparam int T     = 4;
  localparam int B     = 2;
  localparam int FRAME = 2 * T;
  localparam logic [13:0] ERR   = 14'b0000110_0101111;
  localparam logic [13:0] P41   = 14'b0011001_1111001;
  localparam logic [13:0] P0A   = 14'b1000000_0001000;
  localparam logic [13:0] BLANK = 14'h3FFF;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [13:0] seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  seg_scan_ctrl #(.DIGIT_TICKS(T), .BLINK_FRAMES(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [12:0] exp_q[$];  // {an[3:0], seg[6:0], ready, frame_tick}

  // ---------------- reference model (frame level) ----------------
  bit          m_active;   // out of reset
  int          pos;        // position of the current cycle within its frame
  bit          m_full;
  logic [13:0] m_pend;
  logic [13:0] m_shadow;   // pattern committed for the next frame
  logic [13:0] m_disp;     // pattern shown in the current frame
  bit          m_ready;
  int          m_k;        // frames since the displayed pattern was loaded
  bit          m_loaded;

  function automatic logic [12:0] expected_now();
    logic [3:0] an;
    logic [6:0] seg;
    if (!m_active) return {4'hF, 7'h7F, 1'b0, 1'b0};
    if (pos < T) begin an = 4'b1110; seg = m_disp[6:0];  end
    else         begin an = 4'b1101; seg = m_disp[13:7]; end
    if (BLINK && (m_disp == ERR) && (m_k >= B)) an = 4'hF;
    return {an, seg, m_ready, (pos == 0)};
  endfunction

  task automatic model_init();
    m_active = 1'b1; pos = 0; m_full = 1'b0; m_pend = BLANK;
    m_shadow = BLANK; m_disp = BLANK; m_ready = 1'b1; m_k = 0; m_loaded = 1'b0;
  endtask

  // One clock edge of the live model: the frame boundary is the edge that
  // ends the second-to-last cycle of a frame, and a new frame shows whatever
  // was committed there.
  task automatic model_edge(input bit v, input logic [13:0] d);
    if ((pos == FRAME - 2) && m_full) begin
      m_shadow = m_pend; m_full = 1'b0; m_loaded = 1'b1;
    end
    if (v && m_ready) begin
      m_pend = d; m_full = 1'b1;
    end
    m_ready = !m_full;
    pos = (pos + 1) % FRAME;
    if (pos == 0) begin
      m_disp = m_shadow;
      if (m_loaded) m_k = 0;
      else          m_k = (m_k + 1) % (2 * B);
      m_loaded = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [13:0] d, output bit took);
    seg_valid = v;
    seg_in    = d;
    took      = v && m_ready && m_active && !rst;
    @(posedge clk); #1;
    if (rst)            m_active = 1'b0;
    else if (!m_active) model_init();
    else                model_edge(v, d);
    exp_q.push_back(expected_now());
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, 14'($urandom), t);
  endtask

  task automatic idle_to_pos(input int p);
    bit t;
    for (int i = 0; i < FRAME && pos != p; i++) step(1'b0, 14'($urandom), t);
  endtask

  task automatic send(input logic [13:0] d);
    bit took = 1'b0;
    int tries = 0;
    while (!took && tries < 4 * FRAME) begin
      step(1'b1, d, took);
      tries++;
    end
    checks++;
    if (!took) begin
      failures++;
      $display("FAIL send_timeout pattern=%b not accepted within %0d cycles", d, tries);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [12:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {an_out, seg_out, seg_ready, frame_tick};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual an=%b seg=%b rdy=%b ft=%b required an=%b seg=%b rdy=%b ft=%b",
                 $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          hold, took;
    logic [13:0] hd;
    rst = 1'b1; seg_valid = 1'b0; seg_in = '0; m_active = 1'b0;
    pos = 0; m_ready = 1'b0;

    // Reset values, then release.
    do_reset(3);
    idle(2);

    // Single load of "41", then watch three frames.
    send(P41);
    idle(3 * FRAME);

    // Back-to-back: "0A" stalls behind "41" until the boundary.
    do_reset(1);
    idle(1);
    send(P41);
    send(P0A);
    idle(3 * FRAME);

    // Accept in the boundary cycle with pending empty.
    do_reset(2);
    idle_to_pos(FRAME - 2);
    send(P41);
    idle(3 * FRAME);

    // Reset mid-operation during D1 with a pattern pending.
    do_reset(1);
    send(P41);
    idle(2 * FRAME);
    idle_to_pos(1);
    send(P0A);
    idle_to_pos(T + 1);
    do_reset(2);
    idle(2 * FRAME);

    // Error pattern (blinks only when the feature is built in).
    send(ERR);
    idle(6 * FRAME);
    send(P41);
    idle(2 * FRAME);

    // Randomized traffic with a source that holds stalled data.
    hold = 1'b0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold && ($urandom_range(0, 2) == 0)) begin
        hold = 1'b1;
        hd   = ($urandom_range(0, 3) == 0) ? ERR : 14'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      step(hold, hold ? hd : 14'($urandom), took);
      if (took) hold = 1'b0;
    end
    rst = 1'b0;
    idle(2);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending predictions required=0", exp_q.size());
    end
    checks++;
    if (checks < 200) begin
      failures++;
      $display("FAIL check_count actual=%0d required>=200", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
